// File: rtl/lii_rx_filter_fifo.sv
// Receive-side destination filter followed by a first-word-fall-through FIFO.
// Beats addressed to MY_ID are queued; all other beats are swallowed and counted.
module lii_rx_filter_fifo #(
  parameter int          PW    = 1024,
  parameter int          DEPTH = 4,
  parameter logic [7:0]  MY_ID = 8'h00
) (
  input  logic                     aclk,
  input  logic                     arstn,
  input  logic [PW-1:0]            s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [7:0]               s_src,
  input  logic [7:0]               s_dst,
  output logic [PW-1:0]            m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [7:0]               m_src,
  output logic [7:0]               m_dst,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef struct packed {
    logic [PW-1:0] data;
    logic [7:0]    src;
    logic [7:0]    dst;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic            valid_q, valid_d;
  logic [15:0]     drop_q, drop_d;
  logic            match, full, push, pop, drop;
  entry_t          head;

  always_comb begin
    match = (s_dst == MY_ID);
    full  = (occ_q == OW'(DEPTH));
    // Matching beats are refused when full even if a pop happens, so s_tready never depends on m_tready.
    push  = s_tvalid & match & ~full;
    drop  = s_tvalid & ~match;
    pop   = valid_q & m_tready;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    drop_d   = drop_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push & ~pop)      occ_d = occ_q + OW'(1);
    else if (pop & ~push) occ_d = occ_q - OW'(1);

    if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

    valid_d = (occ_d != '0);
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is deliberately left unreset; contents are ignored while m_tvalid is low.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= '{data: s_tdata, src: s_src, dst: s_dst};
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    s_tready  = ~full | (s_tvalid & ~match);
    m_tvalid  = valid_q;
    m_tdata   = head.data;
    m_src     = head.src;
    m_dst     = head.dst;
    occupancy = occ_q;
    drop_cnt  = drop_q;
  end

endmodule

// File: tb/tb_lii_rx_filter_fifo.sv
// Scoreboard bench for lii_rx_filter_fifo: queue-based reference model, separate output monitor.
module tb_lii_rx_filter_fifo;

  localparam int         PW    = 32;
  localparam int         DEPTH = 4;
  localparam logic [7:0] MY_ID = 8'h05;
  localparam int         OW    = $clog2(DEPTH) + 1;

  logic            aclk = 1'b0;
  logic            arstn = 1'b0;
  logic [PW-1:0]   s_tdata = '0;
  logic            s_tvalid = 1'b0;
  logic            s_tready;
  logic [7:0]      s_src = '0;
  logic [7:0]      s_dst = '0;
  logic [PW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tready = 1'b0;
  logic [7:0]      m_src;
  logic [7:0]      m_dst;
  logic [OW-1:0]   occupancy;
  logic [15:0]     drop_cnt;

  lii_rx_filter_fifo #(.PW(PW), .DEPTH(DEPTH), .MY_ID(MY_ID)) dut (
    .aclk(aclk), .arstn(arstn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_src(s_src), .s_dst(s_dst),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_src(m_src), .m_dst(m_dst),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  logic [PW+7:0] exp_q [$];
  int            model_occ  = 0;
  int            model_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: every handshake must deliver the oldest expected beat.
  initial begin
    logic [PW+7:0] e;
    forever begin
      @(negedge aclk);
      if (arstn && m_tvalid === 1'b1 && m_tready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output actual=%0h expected=none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("m_tdata", m_tdata, e[PW+7:8]);
          chk("m_src", {24'd0, m_src}, {24'd0, e[7:0]});
          chk("m_dst", {24'd0, m_dst}, {24'd0, MY_ID});
        end
      end
    end
  end

  // One cycle: drive, check at negedge, advance model at the edge. Entry/exit at posedge+1.
  task automatic step(input logic v, input logic [7:0] dst, input logic [PW-1:0] data,
                      input logic [7:0] src, input logic rdy);
    bit is_match, will_push, will_pop, will_drop;
    s_tvalid = v; s_dst = dst; s_tdata = data; s_src = src; m_tready = rdy;
    is_match  = (dst == MY_ID);
    will_push = v && is_match && (model_occ < DEPTH);
    will_pop  = (model_occ > 0) && rdy;
    will_drop = v && !is_match;
    @(negedge aclk);
    chk("s_tready", {31'd0, s_tready}, {31'd0, (model_occ < DEPTH) || will_drop});
    chk("occupancy", 32'(occupancy), 32'(model_occ));
    chk("m_tvalid", {31'd0, m_tvalid}, {31'd0, model_occ > 0});
    chk("drop_cnt", {16'd0, drop_cnt}, 32'(model_drop));
    @(posedge aclk); #1;
    if (will_push) exp_q.push_back({data, src});
    model_occ = model_occ + (will_push ? 1 : 0) - (will_pop ? 1 : 0);
    if (will_drop && model_drop < 16'hFFFF) model_drop++;
  endtask

  task automatic drain();
    int n = 0;
    while (model_occ > 0 && n < 50) begin
      step(1'b0, 8'h00, '0, 8'h00, 1'b1);
      n++;
    end
    chk("drain_done", 32'(model_occ), 32'd0);
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0; m_tready = 1'b0;
    #2 arstn = 1'b0;
    #1;
    exp_q.delete();
    model_occ = 0; model_drop = 0;
    chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("rst_s_tready", {31'd0, s_tready}, 32'd1);
    @(negedge aclk);
    arstn = 1'b1;
    @(posedge aclk); #1;
  endtask

  function automatic logic [7:0] other_dst();
    logic [7:0] d = 8'($urandom_range(0, 255));
    return (d == MY_ID) ? 8'h06 : d;
  endfunction

  initial begin
    #200000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge aclk); #1;
    do_reset();

    // Pass-through at full rate
    for (int i = 0; i < 8; i++) step(1'b1, MY_ID, PW'(i), 8'(8'h10 + i), 1'b1);
    drain();

    // Fill, backpressure on the 5th beat, single pop, then 5th accepted
    for (int i = 0; i < 4; i++) step(1'b1, MY_ID, PW'(32'hA0 + i), 8'h21, 1'b0);
    chk("full_occ", 32'(occupancy), 32'd4);
    step(1'b1, MY_ID, PW'(32'hA4), 8'h21, 1'b0);
    step(1'b1, MY_ID, PW'(32'hA4), 8'h21, 1'b1);
    step(1'b1, MY_ID, PW'(32'hA4), 8'h21, 1'b0);
    chk("refill_occ", 32'(occupancy), 32'd4);

    // Mismatched beat while full is dropped, not stalled
    step(1'b1, 8'h09, PW'(32'hDEAD), 8'h22, 1'b0);
    chk("drop_while_full", {16'd0, drop_cnt}, 32'd1);
    chk("occ_after_drop", 32'(occupancy), 32'd4);
    drain();

    // Simultaneous push/pop at occupancy 2, wrapping the pointers
    for (int i = 0; i < 2; i++) step(1'b1, MY_ID, PW'(32'hB0 + i), 8'h30, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, MY_ID, PW'($urandom), 8'($urandom), 1'b1);
    chk("steady_occ", 32'(occupancy), 32'd2);
    drain();

    // Randomized mix
    for (int i = 0; i < 400; i++) begin
      logic v  = 1'($urandom_range(0, 3) != 0);
      logic mt = 1'($urandom_range(0, 2) != 0);
      step(v, mt ? MY_ID : other_dst(), PW'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)));
    end
    drain();

    // Reset mid-stream with 3 entries held
    for (int i = 0; i < 3; i++) step(1'b1, MY_ID, PW'(32'hC0 + i), 8'h40, 1'b0);
    step(1'b1, 8'h77, '0, 8'h40, 1'b0);
    chk("pre_reset_occ", 32'(occupancy), 32'd3);
    do_reset();

    // Drop counter saturation
    for (int i = 0; i < 65537; i++) step(1'b1, 8'h33, '0, 8'h00, 1'b1);
    chk("drop_sat", {16'd0, drop_cnt}, 32'h0000FFFF);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h34, '0, 8'h00, 1'b1);
    chk("drop_hold", {16'd0, drop_cnt}, 32'h0000FFFF);
    step(1'b1, MY_ID, PW'(32'h5A5A5A5A), 8'h99, 1'b0);
    chk("post_sat_push", 32'(occupancy), 32'd1);
    drain();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lii_rx_filter_fifo.md
# lii_rx_filter_fifo

Receive-side stage feeding the `lii_in_p0_*` port of a kernel wrapper such as the fc2 stage. It accepts beats from one LII physical input channel and keeps only those whose `dst` tag equals the block's node ID. Kept beats go into a small first-word-fall-through FIFO that decouples link backpressure from kernel stalls. Beats for other nodes are consumed and counted, so a misrouted stream cannot stall the link.

## Interface
Parameters:
- `PW`, 1024, LII packing width (data bits per beat).
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `MY_ID`, 8'h00, node ID; beats with `s_dst == MY_ID` are kept.

Ports (one clock; reset is asynchronous and active-low):
- `aclk`  in  1  clock; all state on rising edge.
- `arstn`  in  1  asynchronous active-low reset.
- `s_tdata`  in  PW  LII phy input data.
- `s_tvalid`  in  1  input beat valid.
- `s_tready`  out  1  input beat accepted.
- `s_src`  in  8  source node tag.
- `s_dst`  in  8  destination node tag.
- `m_tdata`  out  PW  data to the wrapper's `lii_in_p0_tdata`.
- `m_tvalid`  out  1  head entry valid.
- `m_tready`  in  1  wrapper ready.
- `m_src`  out  8  stored source tag of the head entry.
- `m_dst`  out  8  stored destination tag of the head entry; always `MY_ID`.
- `occupancy`  out  $clog2(DEPTH)+1  entries currently held.
- `drop_cnt`  out  16  saturating count of discarded beats.

## Operation
- Definitions: `match = (s_dst == MY_ID)`, `full = (occupancy == DEPTH)`, `empty = (occupancy == 0)`.
- `s_tready = ~full | (s_tvalid & ~match)`. This is combinational on `s_tvalid`/`s_dst` by design. A mismatched beat is never backpressured.
- Push when `s_tvalid & s_tready & match`: write {`s_tdata`, `s_src`, `s_dst`} at `wr_ptr`, then `wr_ptr++`.
- Drop when `s_tvalid & ~match`: the beat is discarded. `drop_cnt` increments and saturates at 16'hFFFF; it never wraps.
- Pop when `m_tvalid & m_tready`: `rd_ptr++`.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- `occupancy` update per cycle: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push and pop in the same cycle are allowed whenever not full.
- When full, `s_tready` is low for matching beats, even if a pop occurs that cycle. There is no pass-through when full. This keeps `s_tready` free of `m_tready`.
- `m_tvalid = ~empty`. `m_tdata`/`m_src`/`m_dst` come from the entry at `rd_ptr`, registered storage, first-word-fall-through.
- Output data is held stable while `m_tvalid & ~m_tready`.
- No data path from `s_*` to `m_*` is combinational.
- Reset (async assert, sync release):
  - `wr_ptr`, `rd_ptr`, `occupancy` = 0; `drop_cnt` = 0; `m_tvalid` = 0.
  - `s_tready` = 1, as it follows `~full`.
  - Storage array is not reset; `m_tdata`/`m_src`/`m_dst` are don't-care while `m_tvalid` = 0.
- Reset mid-operation: all held entries are lost. No partial beat survives.

## Timing
- Latency: a beat pushed at edge N is visible with `m_tvalid` = 1 in the cycle after edge N. That is one cycle, whether or not the FIFO was empty.
- Throughput: one beat per cycle sustained when `m_tready` = 1 continuously, with no bubbles.
- `m_tvalid` and the `m_*` data are register outputs. `s_tready` has one gate level from `s_tvalid`/`s_dst`.
- `full` deasserts the cycle after the pop edge. The first matching beat is then accepted in that cycle.
- `drop_cnt` updates at the edge where the dropped beat is accepted.

## Test plan
- Reset: assert `arstn` = 0 mid-stream with 3 entries held → immediately `m_tvalid` = 0, `occupancy` = 0, `drop_cnt` = 0, `s_tready` = 1.
- Pass-through, DEPTH = 4, MY_ID = 8'h05: stream 8 beats with dst = 5, data = 0..7, `m_tready` = 1 → output 0..7 in order, first valid one cycle after the first push, no bubbles, `occupancy` ≤ 1.
- Fill and backpressure: `m_tready` = 0, push 5 matching beats →
  - first 4 accepted, `occupancy` = 4, `s_tready` = 0 on the 5th;
  - raise `m_tready` for one cycle → pop entry 0, 5th beat accepted the next cycle, order preserved.
- Filtering while full: FIFO full, present dst = 8'h09 → `s_tready` = 1, `drop_cnt` +1, `occupancy` stays 4.
- Simultaneous push/pop at `occupancy` = 2 → `occupancy` stays 2. Run 20 cycles to wrap the pointers; the output sequence must match the reference model.
- Counter saturation: preload by driving 65 537 mismatched beats → `drop_cnt` = 16'hFFFF and holds. Then a matching beat is still enqueued normally.
